idecode: RTL and testbench
==========================

# idecode

Instruction-decode stage of the five-stage MIPS pipeline. Consumes the IF/ID latch (`IF_ID_instr`, `IF_ID_npc`) produced by `ifetch` and contains:

- the 32×32 register file, with writeback from MEM/WB,
- main control decode,
- sign extension,
- the ID/EX pipeline register that feeds the execute stage.

It also accepts a flush from the branch-resolve path (`EX_MEM_PCSrc`).

## Interface
Parameters:
- `RF_RESET_CLEAR`, default 1: when 1, reset zeros all 32 registers. When 0, reset clears only the ID/EX latch.

Ports (reset is synchronous, active-low):
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `IF_ID_instr` input 32: instruction from the IF/ID latch.
- `IF_ID_npc` input 32: PC+4 from the IF/ID latch.
- `EX_MEM_PCSrc` input 1: taken branch; flushes the instruction being latched this cycle.
- `MEM_WB_RegWrite` input 1: writeback enable.
- `MEM_WB_WriteReg` input 5: writeback destination register.
- `MEM_WB_WriteData` input 32: writeback data.
- `ID_EX_wb` output 2: {RegWrite, MemtoReg}.
- `ID_EX_m` output 3: {Branch, MemRead, MemWrite}.
- `ID_EX_ex` output 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `ID_EX_npc` output 32: registered `IF_ID_npc`.
- `ID_EX_readdat1` output 32: rs value.
- `ID_EX_readdat2` output 32: rt value.
- `ID_EX_sign_ext` output 32: sign-extended `instr[15:0]`.
- `ID_EX_instr_2016` output 5: rt field.
- `ID_EX_instr_1511` output 5: rd field.

## Operation
Decode by opcode `instr[31:26]`:
- R-type 0x00: wb=10, m=000, ex=1100.
- lw 0x23: wb=11, m=010, ex=0001.
- sw 0x2B: wb=00, m=001, ex=0001.
- beq 0x04: wb=00, m=100, ex=0010.
- Any other opcode: all control bits 0 (NOP); data fields are still latched.

Register file:
- Read ports are combinational and addressed by rs=`instr[25:21]` and rt=`instr[20:16]`.
- The write port is synchronous and writes when `MEM_WB_RegWrite`=1.
- r0 reads 0 always; writes to r0 are discarded.

Sign extension: `{{16{instr[15]}}, instr[15:0]}`.

Flush: when `EX_MEM_PCSrc`=1 at a rising edge, `ID_EX_wb`, `ID_EX_m` and `ID_EX_ex` load 0. Data fields load normally.

Reset:
- When `rst_n`=0 at a rising edge, all ID_EX outputs load 0.
- If `RF_RESET_CLEAR`=1, all registers also load 0.
- Reset has priority over both flush and writeback.

Reset mid-stream: the instruction in flight is lost. The first decode after reset release is the instruction present on the following cycle.

## Timing
- Latency is 1 cycle: IF_ID inputs sampled at edge N appear on ID_EX outputs after edge N.
- A writeback at edge N is visible to reads after edge N.
- Same-cycle read and write of the same nonzero register: behaviour is defined by `IDECODE_WB_BYPASS_EN` (see Configuration).
- There is no stall input. Load-use hazards are handled elsewhere.
- Flush and writeback in the same cycle are independent; both take effect.

## Configuration
- `IDECODE_WB_BYPASS_EN` defined: when `MEM_WB_RegWrite`=1 and `MEM_WB_WriteReg` equals rs/rt and is nonzero, the read port returns `MEM_WB_WriteData` in that same cycle. This emulates write-first-half/read-second-half.
- Undefined: the read returns the pre-write value. Software must then insert one extra spacing instruction.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ),
  - control-vector widths and bit positions for wb/m/ex.
- One sub-module, `regfile`: 32×32, two async read ports, one sync write port, r0 hardwired, with the bypass under the macro.
- The control decode and ID/EX latch stay in `idecode`.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `IF_ID_instr`=0x8E08FFFC → every ID_EX output is 0, and rs/rt reads are 0.
- **R-type decode:** write r8=0x000000AA and r9=0x00000011 via WB. Then apply instr 0x01095020 (add $10,$8,$9) with npc=0x00000008. Next cycle: readdat1=0xAA, readdat2=0x11, wb=10, m=000, ex=1100, instr_1511=10, npc=0x8.
- **lw decode:** instr 0x8E08FFFC → sign_ext=0xFFFFFFFC, wb=11, m=010, ex=0001, instr_2016=8.
- **Flush:** instr 0x1109FFFF (beq) with `EX_MEM_PCSrc`=1 → wb/m/ex all 0, sign_ext=0xFFFFFFFF.
- **r0 write:** WB write r0=0xDEADBEEF, then read rs=0 → readdat1=0.
- **Bypass:** same-cycle WB r8=0x55 with an instruction reading rs=8 → ID_EX_readdat1 = 0x55 when `IDECODE_WB_BYPASS_EN` is defined, and the prior value when it is undefined.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, control-vector layout and main decode.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    // Unrecognised opcodes decode to an all-zero (NOP) control vector.
    function automatic ctrl_t main_decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.wb[WB_REGWRITE] = 1'b1;
                c.ex[EX_REGDST]   = 1'b1;
                c.ex[EX_ALUOP_HI] = 1'b1;
            end
            OP_LW: begin
                c.wb[WB_REGWRITE] = 1'b1;
                c.wb[WB_MEMTOREG] = 1'b1;
                c.m[M_MEMREAD]    = 1'b1;
                c.ex[EX_ALUSRC]   = 1'b1;
            end
            OP_SW: begin
                c.m[M_MEMWRITE]   = 1'b1;
                c.ex[EX_ALUSRC]   = 1'b1;
            end
            OP_BEQ: begin
                c.m[M_BRANCH]     = 1'b1;
                c.ex[EX_ALUOP_LO] = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/idecode_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port, r0 hardwired to 0.
// Optional same-cycle writeback bypass on the read ports: IDECODE_WB_BYPASS_EN.
module regfile #(
    parameter bit RF_RESET_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];

    // Reset wins over writeback; entry 0 is never written and is masked on read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (RF_RESET_CLEAR) begin
                for (int i = 0; i < 32; i++) begin
                    regs_q[i] <= '0;
                end
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] v;
        v = regs_q[addr];
`ifdef IDECODE_WB_BYPASS_EN
        if (we_i && (waddr_i == addr)) begin
            v = wdata_i;
        end
`endif
        if (addr == 5'd0) begin
            v = '0;
        end
        return v;
    endfunction

    assign rdata1_o = read_port(raddr1_i);
    assign rdata2_o = read_port(raddr2_i);

endmodule

// File: rtl/idecode.sv
// MIPS instruction-decode stage: register file, main control decode, sign extension and ID/EX latch.
// Optional feature macro: IDECODE_WB_BYPASS_EN (forwarded to the register file read ports).
module idecode
    import mips_pkg::*;
#(
    parameter bit RF_RESET_CLEAR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IF_ID_instr,
    input  logic [31:0]      IF_ID_npc,
    input  logic             EX_MEM_PCSrc,
    input  logic             MEM_WB_RegWrite,
    input  logic [4:0]       MEM_WB_WriteReg,
    input  logic [31:0]      MEM_WB_WriteData,
    output logic [WB_W-1:0]  ID_EX_wb,
    output logic [M_W-1:0]   ID_EX_m,
    output logic [EX_W-1:0]  ID_EX_ex,
    output logic [31:0]      ID_EX_npc,
    output logic [31:0]      ID_EX_readdat1,
    output logic [31:0]      ID_EX_readdat2,
    output logic [31:0]      ID_EX_sign_ext,
    output logic [4:0]       ID_EX_instr_2016,
    output logic [4:0]       ID_EX_instr_1511
);

    logic [31:0] rs_data, rt_data;

    regfile #(
        .RF_RESET_CLEAR(RF_RESET_CLEAR)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (IF_ID_instr[25:21]),
        .raddr2_i (IF_ID_instr[20:16]),
        .rdata1_o (rs_data),
        .rdata2_o (rt_data),
        .we_i     (MEM_WB_RegWrite),
        .waddr_i  (MEM_WB_WriteReg),
        .wdata_i  (MEM_WB_WriteData)
    );

    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] rd1_q, rd1_d;
    logic [31:0] rd2_q, rd2_d;
    logic [31:0] sext_q, sext_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rd_q, rd_d;

    // A taken branch squashes only the control bits; data fields pass through.
    always_comb begin
        ctrl_d = main_decode(IF_ID_instr[31:26]);
        if (EX_MEM_PCSrc) begin
            ctrl_d = '0;
        end
        npc_d  = IF_ID_npc;
        rd1_d  = rs_data;
        rd2_d  = rt_data;
        sext_d = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};
        rt_d   = IF_ID_instr[20:16];
        rd_d   = IF_ID_instr[15:11];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            npc_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            sext_q <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            npc_q  <= npc_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            sext_q <= sext_d;
            rt_q   <= rt_d;
            rd_q   <= rd_d;
        end
    end

    assign ID_EX_wb         = ctrl_q.wb;
    assign ID_EX_m          = ctrl_q.m;
    assign ID_EX_ex         = ctrl_q.ex;
    assign ID_EX_npc        = npc_q;
    assign ID_EX_readdat1   = rd1_q;
    assign ID_EX_readdat2   = rd2_q;
    assign ID_EX_sign_ext   = sext_q;
    assign ID_EX_instr_2016 = rt_q;
    assign ID_EX_instr_1511 = rd_q;

endmodule

// File: tb/tb_idecode.sv
// Scoreboard bench for idecode: stimulus pushes expected ID/EX contents, a monitor pops and compares.
module tb_idecode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] IF_ID_instr = '0;
    logic [31:0] IF_ID_npc = '0;
    logic        EX_MEM_PCSrc = 1'b0;
    logic        MEM_WB_RegWrite = 1'b0;
    logic [4:0]  MEM_WB_WriteReg = '0;
    logic [31:0] MEM_WB_WriteData = '0;
    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext;
    logic [4:0]  ID_EX_instr_2016, ID_EX_instr_1511;

    idecode dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IF_ID_instr      (IF_ID_instr),
        .IF_ID_npc        (IF_ID_npc),
        .EX_MEM_PCSrc     (EX_MEM_PCSrc),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .MEM_WB_WriteReg  (MEM_WB_WriteReg),
        .MEM_WB_WriteData (MEM_WB_WriteData),
        .ID_EX_wb         (ID_EX_wb),
        .ID_EX_m          (ID_EX_m),
        .ID_EX_ex         (ID_EX_ex),
        .ID_EX_npc        (ID_EX_npc),
        .ID_EX_readdat1   (ID_EX_readdat1),
        .ID_EX_readdat2   (ID_EX_readdat2),
        .ID_EX_sign_ext   (ID_EX_sign_ext),
        .ID_EX_instr_2016 (ID_EX_instr_2016),
        .ID_EX_instr_1511 (ID_EX_instr_1511)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       name;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, sext;
        logic [4:0]  rt, rd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic done = 1'b0;

`ifdef IDECODE_WB_BYPASS_EN
    localparam logic [31:0] BYPASS_RD1 = 32'h55;
`else
    localparam logic [31:0] BYPASS_RD1 = 32'hAA;
`endif

    task automatic chk(input string txn, input string fld, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", txn, fld, act, req);
        end
    endtask

    // Monitor: the ID/EX latch presents a new entry one sample after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk(e.name, "wb",   {30'd0, ID_EX_wb},         {30'd0, e.wb});
                chk(e.name, "m",    {29'd0, ID_EX_m},          {29'd0, e.m});
                chk(e.name, "ex",   {28'd0, ID_EX_ex},         {28'd0, e.ex});
                chk(e.name, "npc",  ID_EX_npc,                 e.npc);
                chk(e.name, "rd1",  ID_EX_readdat1,            e.rd1);
                chk(e.name, "rd2",  ID_EX_readdat2,            e.rd2);
                chk(e.name, "sext", ID_EX_sign_ext,            e.sext);
                chk(e.name, "rt",   {27'd0, ID_EX_instr_2016}, {27'd0, e.rt});
                chk(e.name, "rd",   {27'd0, ID_EX_instr_1511}, {27'd0, e.rd});
                $display("[TB] txn %-10s wb=%b m=%b ex=%b npc=%h rd1=%h rd2=%h sext=%h rt=%0d rd=%0d",
                         e.name, ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_npc, ID_EX_readdat1,
                         ID_EX_readdat2, ID_EX_sign_ext, ID_EX_instr_2016, ID_EX_instr_1511);
            end
        end
    end

    task automatic drive(input logic rst, input logic [31:0] instr, input logic [31:0] npc,
                         input logic pcsrc, input logic we, input logic [4:0] wreg,
                         input logic [31:0] wdata);
        @(negedge clk);
        rst_n            = rst;
        IF_ID_instr      = instr;
        IF_ID_npc        = npc;
        EX_MEM_PCSrc     = pcsrc;
        MEM_WB_RegWrite  = we;
        MEM_WB_WriteReg  = wreg;
        MEM_WB_WriteData = wdata;
    endtask

    task automatic expect_out(input string name, input logic [1:0] wb, input logic [2:0] m,
                              input logic [3:0] ex, input logic [31:0] npc, input logic [31:0] rd1,
                              input logic [31:0] rd2, input logic [31:0] sext,
                              input logic [4:0] rt, input logic [4:0] rd);
        exp_t e;
        e.due = cyc + 1;
        e.name = name;
        e.wb = wb; e.m = m; e.ex = ex;
        e.npc = npc; e.rd1 = rd1; e.rd2 = rd2; e.sext = sext;
        e.rt = rt; e.rd = rd;
        q.push_back(e);
    endtask

    initial begin
        // Reset held two cycles with a lw on the bus: everything reads 0.
        drive(1'b0, 32'h8E08FFFC, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_out("reset0", 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        drive(1'b0, 32'h8E08FFFC, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_out("reset1", 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        // First decode after release; writeback r8.
        drive(1'b1, 32'h00000000, 32'h0, 1'b0, 1'b1, 5'd8, 32'hAA);
        expect_out("rtype0", 2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        // Unknown opcode decodes as NOP; writeback r9.
        drive(1'b1, 32'hFC000000, 32'h4, 1'b0, 1'b1, 5'd9, 32'h11);
        expect_out("nop", 2'b00, 3'b000, 4'b0000, 32'h4, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        // add $10,$8,$9
        drive(1'b1, 32'h01095020, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_out("add", 2'b10, 3'b000, 4'b1100, 32'h8, 32'hAA, 32'h11, 32'h00005020, 5'd9, 5'd10);
        // lw $8,-4($16)
        drive(1'b1, 32'h8E08FFFC, 32'hC, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_out("lw", 2'b11, 3'b010, 4'b0001, 32'hC, 32'h0, 32'hAA, 32'hFFFFFFFC, 5'd8, 5'd31);
        // sw $9,4($8)
        drive(1'b1, 32'hAD090004, 32'h10, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_out("sw", 2'b00, 3'b001, 4'b0001, 32'h10, 32'hAA, 32'h11, 32'h4, 5'd9, 5'd0);
        // Flushed beq with a concurrent writeback of r10.
        drive(1'b1, 32'h1109FFFF, 32'h14, 1'b1, 1'b1, 5'd10, 32'h1234);
        expect_out("beq_flush", 2'b00, 3'b000, 4'b0000, 32'h14, 32'hAA, 32'h11, 32'hFFFFFFFF, 5'd9, 5'd31);
        // Unflushed beq; attempted write of r0.
        drive(1'b1, 32'h1109FFFF, 32'h18, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
        expect_out("beq", 2'b00, 3'b100, 4'b0010, 32'h18, 32'hAA, 32'h11, 32'hFFFFFFFF, 5'd9, 5'd31);
        // Read r0 (must stay 0) and r10 (written during the flush).
        drive(1'b1, 32'h000A0000, 32'h1C, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_out("r0_r10", 2'b10, 3'b000, 4'b1100, 32'h1C, 32'h0, 32'h1234, 32'h0, 5'd10, 5'd0);
        // Same-cycle writeback of r8 while reading it.
        drive(1'b1, 32'h01095020, 32'h20, 1'b0, 1'b1, 5'd8, 32'h55);
        expect_out("bypass", 2'b10, 3'b000, 4'b1100, 32'h20, BYPASS_RD1, 32'h11, 32'h00005020, 5'd9, 5'd10);
        drive(1'b1, 32'h01095020, 32'h24, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_out("after_wb", 2'b10, 3'b000, 4'b1100, 32'h24, 32'h55, 32'h11, 32'h00005020, 5'd9, 5'd10);
        // Mid-stream reset with writeback pending: reset wins, registers cleared.
        drive(1'b0, 32'h8E08FFFC, 32'h28, 1'b1, 1'b1, 5'd9, 32'h99);
        expect_out("reset_mid", 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        drive(1'b1, 32'h01095020, 32'h2C, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_out("post_rst", 2'b10, 3'b000, 4'b1100, 32'h2C, 32'h0, 32'h0, 32'h00005020, 5'd9, 5'd10);
        drive(1'b1, 32'h00000000, 32'h30, 1'b0, 1'b0, 5'd0, 32'h0);
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain actual=%0d pending required=0", q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("[TB] FAIL timeout actual=%0d cycles required=finish", cyc);
            $fatal(1, "timeout");
        end
    end

endmodule
